// File: rtl/tage_update_ctrl_if.sv
// Bundle between the TAGE selector/resolution logic and the training stage:
// prediction metadata in, resolution in, registered update commands out.
interface tage_update_ctrl_if #(
    parameter int N_COMPONENTS = 5,
    parameter int CTR_WIDTH    = 3,
    parameter int U_WIDTH      = 2,
    parameter int DEPTH        = 8
);
    localparam int IDX_W = $clog2(N_COMPONENTS);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic                 pred_valid;
    logic                 pred_ready;
    logic [IDX_W-1:0]     pred_provider;
    logic [IDX_W-1:0]     pred_alternate;
    logic                 pred_taken;
    logic                 pred_alt_taken;
    logic [CTR_WIDTH-1:0] pred_ctr;
    logic [U_WIDTH-1:0]   pred_u;

    logic                 res_valid;
    logic                 res_taken;
    logic                 res_flush;

    logic                 upd_valid;
    logic [IDX_W-1:0]     upd_comp;
    logic [CTR_WIDTH-1:0] upd_ctr;
    logic                 upd_u_valid;
    logic [U_WIDTH-1:0]   upd_u;
    logic                 alloc_valid;
    logic [IDX_W-1:0]     alloc_start;
    logic                 u_decay;
    logic [CNT_W-1:0]     queue_count;

    modport master (
        output pred_valid, pred_provider, pred_alternate, pred_taken,
               pred_alt_taken, pred_ctr, pred_u,
               res_valid, res_taken, res_flush,
        input  pred_ready, upd_valid, upd_comp, upd_ctr, upd_u_valid, upd_u,
               alloc_valid, alloc_start, u_decay, queue_count
    );

    modport slave (
        input  pred_valid, pred_provider, pred_alternate, pred_taken,
               pred_alt_taken, pred_ctr, pred_u,
               res_valid, res_taken, res_flush,
        output pred_ready, upd_valid, upd_comp, upd_ctr, upd_u_valid, upd_u,
               alloc_valid, alloc_start, u_decay, queue_count
    );
endinterface

// File: rtl/tage_update_ctrl.sv
// TAGE training stage: in-order metadata queue popped on branch resolution,
// producing registered counter/useful/allocation/decay update commands.
module tage_update_ctrl #(
    parameter int N_COMPONENTS   = 5,
    parameter int CTR_WIDTH      = 3,
    parameter int U_WIDTH        = 2,
    parameter int DEPTH          = 8,
    parameter int U_RESET_PERIOD = 256
) (
    input  logic              clk,
    input  logic              rst,
    tage_update_ctrl_if.slave bus
);
    localparam int IDX_W = $clog2(N_COMPONENTS);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int DEC_W = $clog2(U_RESET_PERIOD);

    localparam logic [CTR_WIDTH-1:0] CTR_MAX  = '1;
    localparam logic [U_WIDTH-1:0]   U_MAX    = '1;
    localparam logic [IDX_W-1:0]     LAST_IDX = IDX_W'(N_COMPONENTS - 1);
    localparam logic [DEC_W-1:0]     DEC_LAST = DEC_W'(U_RESET_PERIOD - 1);

    typedef struct packed {
        logic [IDX_W-1:0]     provider;
        logic                 taken;
        logic                 alt_taken;
        logic [CTR_WIDTH-1:0] ctr;
        logic [U_WIDTH-1:0]   u;
    } meta_t;

    meta_t                mem_q [DEPTH];
    logic [PTR_W-1:0]     head_q, tail_q;
    logic [CNT_W-1:0]     count_q;
    logic [DEC_W-1:0]     decay_q;

    logic                 upd_valid_q, upd_u_valid_q, alloc_valid_q, u_decay_q;
    logic [IDX_W-1:0]     upd_comp_q, alloc_start_q;
    logic [CTR_WIDTH-1:0] upd_ctr_q;
    logic [U_WIDTH-1:0]   upd_u_q;

    logic                 upd_u_valid_d, alloc_valid_d, u_decay_d;
    logic [IDX_W-1:0]     upd_comp_d, alloc_start_d;
    logic [CTR_WIDTH-1:0] upd_ctr_d;
    logic [U_WIDTH-1:0]   upd_u_d;
    logic [DEC_W-1:0]     decay_d;

    logic  full, push, pop;
    meta_t head, in_entry;

    assign full = (count_q == CNT_W'(DEPTH));
    assign push = bus.pred_valid && !full;
    assign pop  = bus.res_valid && (count_q != '0);
    assign head = mem_q[head_q];

    assign in_entry = '{provider:  bus.pred_provider,
                        taken:     bus.pred_taken,
                        alt_taken: bus.pred_alt_taken,
                        ctr:       bus.pred_ctr,
                        u:         bus.pred_u};

    // A push coinciding with a flush belongs to the squashed path, so it is not stored.
    always_ff @(posedge clk) begin
        if (push && !bus.res_flush) begin
            mem_q[tail_q] <= in_entry;
        end
    end

    always_comb begin
        upd_comp_d    = '0;
        upd_ctr_d     = '0;
        upd_u_valid_d = 1'b0;
        upd_u_d       = '0;
        alloc_valid_d = 1'b0;
        alloc_start_d = '0;
        u_decay_d     = 1'b0;
        decay_d       = decay_q;
        if (pop) begin
            upd_comp_d = head.provider;
            if (bus.res_taken) begin
                upd_ctr_d = (head.ctr == CTR_MAX) ? head.ctr : head.ctr + CTR_WIDTH'(1);
            end else begin
                upd_ctr_d = (head.ctr == '0) ? head.ctr : head.ctr - CTR_WIDTH'(1);
            end
            // Usefulness only moves when provider and alternate disagreed.
            upd_u_valid_d = (head.provider != '0) && (head.taken != head.alt_taken);
            if (upd_u_valid_d) begin
                if (head.taken == bus.res_taken) begin
                    upd_u_d = (head.u == U_MAX) ? head.u : head.u + U_WIDTH'(1);
                end else begin
                    upd_u_d = (head.u == '0) ? head.u : head.u - U_WIDTH'(1);
                end
            end
            alloc_valid_d = (head.taken != bus.res_taken) && (head.provider < LAST_IDX);
            if (alloc_valid_d) begin
                alloc_start_d = head.provider + IDX_W'(1);
            end
            u_decay_d = (decay_q == DEC_LAST);
            decay_d   = u_decay_d ? '0 : decay_q + DEC_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q        <= '0;
            tail_q        <= '0;
            count_q       <= '0;
            decay_q       <= '0;
            upd_valid_q   <= 1'b0;
            upd_comp_q    <= '0;
            upd_ctr_q     <= '0;
            upd_u_valid_q <= 1'b0;
            upd_u_q       <= '0;
            alloc_valid_q <= 1'b0;
            alloc_start_q <= '0;
            u_decay_q     <= 1'b0;
        end else begin
            if (bus.res_flush) begin
                head_q  <= '0;
                tail_q  <= '0;
                count_q <= '0;
            end else begin
                if (push) tail_q <= tail_q + PTR_W'(1);
                if (pop)  head_q <= head_q + PTR_W'(1);
                count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
            end
            decay_q       <= decay_d;
            upd_valid_q   <= pop;
            upd_comp_q    <= upd_comp_d;
            upd_ctr_q     <= upd_ctr_d;
            upd_u_valid_q <= upd_u_valid_d;
            upd_u_q       <= upd_u_d;
            alloc_valid_q <= alloc_valid_d;
            alloc_start_q <= alloc_start_d;
            u_decay_q     <= u_decay_d;
        end
    end

    assign bus.pred_ready  = !full;
    assign bus.queue_count = count_q;
    assign bus.upd_valid   = upd_valid_q;
    assign bus.upd_comp    = upd_comp_q;
    assign bus.upd_ctr     = upd_ctr_q;
    assign bus.upd_u_valid = upd_u_valid_q;
    assign bus.upd_u       = upd_u_q;
    assign bus.alloc_valid = alloc_valid_q;
    assign bus.alloc_start = alloc_start_q;
    assign bus.u_decay     = u_decay_q;
endmodule

// File: tb/tb_tage_update_ctrl.sv
// Directed bench for tage_update_ctrl with an in-bench queue model checked every cycle.
module tb_tage_update_ctrl;
    localparam int N_COMP = 5;
    localparam int CTR_W  = 3;
    localparam int U_W    = 2;
    localparam int DEPTH  = 8;
    localparam int PERIOD = 256;
    localparam int CTR_MAXV = (1 << CTR_W) - 1;
    localparam int U_MAXV   = (1 << U_W) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    tage_update_ctrl_if #(.N_COMPONENTS(N_COMP), .CTR_WIDTH(CTR_W), .U_WIDTH(U_W),
                          .DEPTH(DEPTH)) bus ();

    tage_update_ctrl #(.N_COMPONENTS(N_COMP), .CTR_WIDTH(CTR_W), .U_WIDTH(U_W),
                       .DEPTH(DEPTH), .U_RESET_PERIOD(PERIOD)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        int prov;
        int alt;
        bit taken;
        bit alt_taken;
        int ctr;
        int u;
    } pred_t;

    pred_t mq[$];
    int    since_decay = 0;
    int    n_checks = 0;
    int    n_fail   = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic clear_inputs();
        bus.pred_valid     = 1'b0;
        bus.pred_provider  = '0;
        bus.pred_alternate = '0;
        bus.pred_taken     = 1'b0;
        bus.pred_alt_taken = 1'b0;
        bus.pred_ctr       = '0;
        bus.pred_u         = '0;
        bus.res_valid      = 1'b0;
        bus.res_taken      = 1'b0;
        bus.res_flush      = 1'b0;
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_upd_valid"},   int'(bus.upd_valid), 0);
        chk({tag, "_upd_ctr"},     int'(bus.upd_ctr), 0);
        chk({tag, "_alloc_valid"}, int'(bus.alloc_valid), 0);
        chk({tag, "_u_decay"},     int'(bus.u_decay), 0);
        chk({tag, "_count"},       int'(bus.queue_count), 0);
        chk({tag, "_ready"},       int'(bus.pred_ready), 1);
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        mq.delete();
        since_decay = 0;
        repeat (2) @(posedge clk);
        #1;
        chk_idle_outputs("reset");
        rst = 1'b0;
        $display("reset applied");
    endtask

    // One clock: drive inputs, advance the model, check every output after the edge.
    task automatic step(input bit pv, input int prov, input int alt, input bit tk,
                        input bit atk, input int ctr, input int u,
                        input bit rv, input bit rt, input bit rf);
        pred_t p;
        bit    can_push;
        int    e_valid, e_comp, e_ctr, e_uv, e_u, e_alloc, e_start, e_decay;
        bus.pred_valid     = pv;
        bus.pred_provider  = 3'(prov);
        bus.pred_alternate = 3'(alt);
        bus.pred_taken     = tk;
        bus.pred_alt_taken = atk;
        bus.pred_ctr       = 3'(ctr);
        bus.pred_u         = 2'(u);
        bus.res_valid      = rv;
        bus.res_taken      = rt;
        bus.res_flush      = rf;
        chk("pre_ready", int'(bus.pred_ready), (mq.size() < DEPTH) ? 1 : 0);
        chk("pre_count", int'(bus.queue_count), mq.size());

        {e_valid, e_comp, e_ctr, e_uv, e_u, e_alloc, e_start, e_decay} = '0;
        can_push = (mq.size() < DEPTH);
        if (rv && mq.size() > 0) begin
            p       = mq.pop_front();
            e_valid = 1;
            e_comp  = p.prov;
            e_ctr   = rt ? ((p.ctr + 1 > CTR_MAXV) ? CTR_MAXV : p.ctr + 1)
                         : ((p.ctr - 1 < 0) ? 0 : p.ctr - 1);
            if (p.prov != 0 && p.taken != p.alt_taken) begin
                e_uv = 1;
                e_u  = (p.taken == rt) ? ((p.u + 1 > U_MAXV) ? U_MAXV : p.u + 1)
                                       : ((p.u - 1 < 0) ? 0 : p.u - 1);
            end
            if (p.taken != rt && p.prov < N_COMP - 1) begin
                e_alloc = 1;
                e_start = p.prov + 1;
            end
            since_decay++;
            if (since_decay == PERIOD) begin
                e_decay     = 1;
                since_decay = 0;
            end
        end
        if (rf) mq.delete();
        else if (pv && can_push) begin
            p = '{prov: prov, alt: alt, taken: tk, alt_taken: atk, ctr: ctr, u: u};
            mq.push_back(p);
        end

        @(posedge clk);
        #1;
        clear_inputs();
        chk("upd_valid",   int'(bus.upd_valid),   e_valid);
        chk("upd_comp",    int'(bus.upd_comp),    e_comp);
        chk("upd_ctr",     int'(bus.upd_ctr),     e_ctr);
        chk("upd_u_valid", int'(bus.upd_u_valid), e_uv);
        chk("upd_u",       int'(bus.upd_u),       e_u);
        chk("alloc_valid", int'(bus.alloc_valid), e_alloc);
        chk("alloc_start", int'(bus.alloc_start), e_start);
        chk("u_decay",     int'(bus.u_decay),     e_decay);
        chk("queue_count", int'(bus.queue_count), mq.size());
        $display("txn pv=%0d rv=%0d rf=%0d -> upd=%0d comp=%0d ctr=%0d uv=%0d u=%0d alloc=%0d/%0d decay=%0d count=%0d",
                 pv, rv, rf, bus.upd_valid, bus.upd_comp, bus.upd_ctr, bus.upd_u_valid,
                 bus.upd_u, bus.alloc_valid, bus.alloc_start, bus.u_decay, bus.queue_count);
    endtask

    task automatic push_only(input int prov, input int alt, input bit tk, input bit atk,
                             input int ctr, input int u);
        step(1'b1, prov, alt, tk, atk, ctr, u, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic resolve(input bit rt);
        step(1'b0, 0, 0, 1'b0, 1'b0, 0, 0, 1'b1, rt, 1'b0);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int pulses;
        int pulse_at;
        clear_inputs();
        do_reset();

        // Test 1: saturated counter, useful increment, no allocation
        push_only(3, 1, 1'b1, 1'b0, 7, 3);
        resolve(1'b1);
        chk("t1_comp",  int'(bus.upd_comp), 3);
        chk("t1_ctr",   int'(bus.upd_ctr), 7);
        chk("t1_uv",    int'(bus.upd_u_valid), 1);
        chk("t1_u",     int'(bus.upd_u), 3);
        chk("t1_alloc", int'(bus.alloc_valid), 0);

        // Test 2: misprediction from provider 2
        push_only(2, 0, 1'b1, 1'b0, 4, 1);
        resolve(1'b0);
        chk("t2_ctr",   int'(bus.upd_ctr), 3);
        chk("t2_u",     int'(bus.upd_u), 0);
        chk("t2_alloc", int'(bus.alloc_valid), 1);
        chk("t2_start", int'(bus.alloc_start), 3);

        // Test 3: last component cannot allocate; base predictor at floor
        push_only(4, 2, 1'b1, 1'b0, 5, 2);
        resolve(1'b0);
        chk("t3_alloc_last", int'(bus.alloc_valid), 0);
        push_only(0, 0, 1'b0, 1'b0, 0, 0);
        resolve(1'b0);
        chk("t3_comp", int'(bus.upd_comp), 0);
        chk("t3_ctr",  int'(bus.upd_ctr), 0);
        chk("t3_uv",   int'(bus.upd_u_valid), 0);

        // Test 4: fill to full, reject overflow, FIFO order on drain
        for (int i = 0; i < DEPTH; i++)
            push_only(i % N_COMP, (i + 1) % N_COMP, 1'(i), 1'(i >> 1), i % 8, i % 4);
        chk("t4_ready_full", int'(bus.pred_ready), 0);
        chk("t4_count_full", int'(bus.queue_count), 8);
        push_only(1, 0, 1'b1, 1'b0, 2, 2);
        chk("t4_count_9th", int'(bus.queue_count), 8);
        step(1'b1, 2, 1, 1'b0, 1'b1, 6, 1, 1'b1, 1'b1, 1'b0);
        chk("t4_count_pp", int'(bus.queue_count), 7);
        chk("t4_first_comp", int'(bus.upd_comp), 0);
        for (int i = 0; i < 7; i++) resolve(1'(i & 1));
        chk("t4_drained", int'(bus.queue_count), 0);

        // Test 5: flush with pop and push in the same cycle
        push_only(1, 0, 1'b1, 1'b0, 2, 1);
        push_only(2, 1, 1'b0, 1'b1, 3, 2);
        push_only(3, 2, 1'b1, 1'b1, 4, 3);
        step(1'b1, 4, 3, 1'b1, 1'b0, 5, 1, 1'b1, 1'b1, 1'b1);
        chk("t5_upd_valid", int'(bus.upd_valid), 1);
        chk("t5_comp",      int'(bus.upd_comp), 1);
        chk("t5_count",     int'(bus.queue_count), 0);
        resolve(1'b1);
        chk("t5_empty_res", int'(bus.upd_valid), 0);

        // Test 6: decay pulse exactly on the 256th update
        do_reset();
        pulses = 0;
        pulse_at = -1;
        for (int i = 0; i < PERIOD; i++) begin
            push_only(i % N_COMP, 0, 1'(i), 1'(i >> 2), i % 8, i % 4);
            resolve(1'(i >> 1));
            if (bus.u_decay) begin
                pulses++;
                pulse_at = i;
            end
        end
        chk("t6_pulses", pulses, 1);
        chk("t6_pulse_at", pulse_at, PERIOD - 1);

        // 100 pops, then asynchronous reset while an update is on the outputs
        for (int i = 0; i < 100; i++) begin
            push_only(1, 0, 1'b1, 1'b0, 3, 1);
            resolve(1'b1);
        end
        chk("t6_pre_rst_valid", int'(bus.upd_valid), 1);
        #2;
        rst = 1'b1;
        #1;
        chk("t6_async_valid", int'(bus.upd_valid), 0);
        chk("t6_async_ctr",   int'(bus.upd_ctr), 0);
        mq.delete();
        since_decay = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        $display("asynchronous reset applied mid-operation");

        pulses = 0;
        pulse_at = -1;
        for (int i = 0; i < PERIOD; i++) begin
            push_only(2, 1, 1'b0, 1'b1, 4, 2);
            resolve(1'b0);
            if (bus.u_decay) begin
                pulses++;
                pulse_at = i;
            end
        end
        chk("t6_post_rst_pulses", pulses, 1);
        chk("t6_post_rst_at", pulse_at, PERIOD - 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
